// File: rtl/pixel_server.sv
// pixel_server: serves pixel read requests from an external image memory.
// Range-checks addresses, counts responses and flags bad requests.
module pixel_server #(
    parameter logic [31:0] BASE_ADDR = 32'h0004_0000,
    parameter int          IMG_W     = 64,
    parameter int          IMG_H     = 64,
    parameter int          MEM_LAT   = 1,
    parameter logic [31:0] OOB_VALUE = 32'hDEAD_BEEF,
    parameter int          MEM_AW    = 12
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic [31:0]       addr_pixel,
    input  logic              request_pixel,
    output logic [31:0]       pixel,
    output logic              pixel_avail,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [15:0]       req_count,
    output logic              err_oob
);

    localparam logic [31:0] NPIX     = 32'(IMG_W * IMG_H);
    localparam logic [3:0]  LAT_INIT = 4'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_RESP,
        S_REARM
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pixel_q, pixel_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        lat_q, lat_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [31:0] diff;
    logic [31:0] idx;
    logic        bad;

    // Address decode of the incoming request (only used in IDLE).
    always_comb begin
        diff = addr_pixel - BASE_ADDR;
        idx  = diff >> 2;
        bad  = (addr_pixel[1:0] != 2'b00)
            || (addr_pixel < BASE_ADDR)
            || (idx >= NPIX);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= S_IDLE;
            pixel_q    <= 32'h0;
            mem_addr_q <= '0;
            lat_q      <= 4'h0;
            cnt_q      <= 16'h0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pixel_q    <= pixel_d;
            mem_addr_q <= mem_addr_d;
            lat_q      <= lat_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and strobe logic.
    always_comb begin
        state_d     = state_q;
        pixel_d     = pixel_q;
        mem_addr_d  = mem_addr_q;
        lat_d       = lat_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_en      = 1'b0;
        pixel_avail = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (request_pixel) begin
                    if (bad) begin
                        pixel_d = OOB_VALUE;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        mem_addr_d = idx[MEM_AW-1:0];
                        state_d    = S_READ;
                    end
                end
            end
            S_READ: begin
                mem_en  = 1'b1;
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - 4'd1;
                if (lat_q == 4'd1) begin
                    pixel_d = mem_rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                pixel_avail = 1'b1;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
                state_d = S_REARM;
            end
            S_REARM: begin
                if (!request_pixel) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pixel     = pixel_q;
    assign mem_addr  = mem_addr_q;
    assign req_count = cnt_q;
    assign err_oob   = err_q;

endmodule

// File: tb/tb_pixel_server.sv
// tb_pixel_server: directed bench for pixel_server.
// Two instances (read latency 1 and 3) share one requester.
module tb_pixel_server;

    localparam logic [31:0] BASE = 32'h0004_0000;

    logic        clk;
    logic        res_n;
    logic [31:0] addr_pixel;
    logic        request_pixel;

    logic [31:0] pix_a, pix_b;
    logic        av_a, av_b;
    logic        en_a, en_b;
    logic [11:0] maddr_a, maddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [15:0] cnt_a, cnt_b;
    logic        err_a, err_b;

    logic [31:0] mem [0:4095];
    logic [31:0] a_d1;
    logic [31:0] b_d1, b_d2, b_d3;

    int checks = 0;
    int errors = 0;

    int a_en_first, a_en_cnt, a_av_first, a_av_cnt;
    int b_en_first, b_en_cnt, b_av_first, b_av_cnt;
    logic [11:0] a_en_addr, b_en_addr;
    logic [31:0] a_pix, b_pix;

    pixel_server #(.MEM_LAT(1)) dut_a (
        .clk(clk), .res_n(res_n),
        .addr_pixel(addr_pixel), .request_pixel(request_pixel),
        .pixel(pix_a), .pixel_avail(av_a),
        .mem_en(en_a), .mem_addr(maddr_a), .mem_rdata(rdata_a),
        .req_count(cnt_a), .err_oob(err_a)
    );

    pixel_server #(.MEM_LAT(3)) dut_b (
        .clk(clk), .res_n(res_n),
        .addr_pixel(addr_pixel), .request_pixel(request_pixel),
        .pixel(pix_b), .pixel_avail(av_b),
        .mem_en(en_b), .mem_addr(maddr_b), .mem_rdata(rdata_b),
        .req_count(cnt_b), .err_oob(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memories; data is zero except in the valid slot.
    always @(posedge clk) begin
        a_d1 <= en_a ? mem[maddr_a] : 32'h0;
        b_d1 <= en_b ? mem[maddr_b] : 32'h0;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign rdata_a = a_d1;
    assign rdata_b = b_d3;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller is just after a posedge; request is high in cycle 0.
    task automatic observe(input int win, input int drop_at);
        a_en_first = -1; a_en_cnt = 0; a_av_first = -1; a_av_cnt = 0;
        b_en_first = -1; b_en_cnt = 0; b_av_first = -1; b_av_cnt = 0;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            if (en_a) begin
                if (a_en_first < 0) a_en_first = c;
                a_en_cnt++;
                a_en_addr = maddr_a;
            end
            if (en_b) begin
                if (b_en_first < 0) b_en_first = c;
                b_en_cnt++;
                b_en_addr = maddr_b;
            end
            if (av_a) begin
                if (a_av_first < 0) a_av_first = c;
                a_av_cnt++;
                a_pix = pix_a;
            end
            if (av_b) begin
                if (b_av_first < 0) b_av_first = c;
                b_av_cnt++;
                b_pix = pix_b;
            end
            @(posedge clk);
            #1;
            if (c + 1 == drop_at) request_pixel = 1'b0;
        end
    endtask

    task automatic run_req(input logic [31:0] a, input int win,
                           input int drop_at);
        addr_pixel    = a;
        request_pixel = 1'b1;
        observe(win, drop_at);
        addr_pixel = 32'hFFFF_FFFF;
    endtask

    task automatic chk_good(input string t, input logic [11:0] ea,
                            input logic [31:0] ep);
        chk({t, "_a_en_first"}, a_en_first, 1);
        chk({t, "_a_en_cnt"}, a_en_cnt, 1);
        chk({t, "_a_en_addr"}, a_en_addr, ea);
        chk({t, "_a_av_first"}, a_av_first, 3);
        chk({t, "_a_av_cnt"}, a_av_cnt, 1);
        chk({t, "_a_pix"}, a_pix, ep);
        chk({t, "_b_en_first"}, b_en_first, 1);
        chk({t, "_b_en_cnt"}, b_en_cnt, 1);
        chk({t, "_b_en_addr"}, b_en_addr, ea);
        chk({t, "_b_av_first"}, b_av_first, 5);
        chk({t, "_b_av_cnt"}, b_av_cnt, 1);
        chk({t, "_b_pix"}, b_pix, ep);
    endtask

    task automatic chk_bad(input string t);
        chk({t, "_a_en_cnt"}, a_en_cnt, 0);
        chk({t, "_a_av_first"}, a_av_first, 1);
        chk({t, "_a_av_cnt"}, a_av_cnt, 1);
        chk({t, "_a_pix"}, a_pix, 32'hDEAD_BEEF);
        chk({t, "_a_err"}, err_a, 1);
        chk({t, "_b_en_cnt"}, b_en_cnt, 0);
        chk({t, "_b_av_first"}, b_av_first, 1);
        chk({t, "_b_pix"}, b_pix, 32'hDEAD_BEEF);
        chk({t, "_b_err"}, err_b, 1);
    endtask

    task automatic chk_zero(input string t);
        chk({t, "_a_pixel"}, pix_a, 0);
        chk({t, "_a_avail"}, av_a, 0);
        chk({t, "_a_en"}, en_a, 0);
        chk({t, "_a_maddr"}, maddr_a, 0);
        chk({t, "_a_count"}, cnt_a, 0);
        chk({t, "_a_err"}, err_a, 0);
        chk({t, "_b_pixel"}, pix_b, 0);
        chk({t, "_b_avail"}, av_b, 0);
        chk({t, "_b_en"}, en_b, 0);
        chk({t, "_b_count"}, cnt_b, 0);
        chk({t, "_b_err"}, err_b, 0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        mem[5]    = 32'h00AB_CDEF;
        mem[100]  = 32'h1234_5678;
        mem[4095] = 32'hCAFE_F00D;

        res_n         = 1'b0;
        request_pixel = 1'b0;
        addr_pixel    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Good request to word 5.
        run_req(BASE + 32'd20, 8, 7);
        chk_good("w5", 12'd5, 32'h00AB_CDEF);
        chk("w5_a_count", cnt_a, 1);
        chk("w5_b_count", cnt_b, 1);
        chk("w5_a_err", err_a, 0);
        chk("w5_a_maddr_hold", maddr_a, 5);

        // Last pixel in the image.
        run_req(BASE + 32'd16380, 8, 7);
        chk_good("w4095", 12'd4095, 32'hCAFE_F00D);
        chk("w4095_a_count", cnt_a, 2);

        // One past the end of the image.
        run_req(BASE + 32'd16384, 8, 7);
        chk_bad("oob_end");
        chk("oob_end_a_maddr", maddr_a, 4095);

        // Misaligned address.
        run_req(BASE + 32'd2, 8, 7);
        chk_bad("misalign");

        // Below the base address.
        run_req(BASE - 32'd4, 8, 7);
        chk_bad("below");
        chk("below_a_count", cnt_a, 5);
        chk("below_b_count", cnt_b, 5);

        // Request held long after the response: one response only.
        run_req(BASE + 32'd400, 27, 26);
        chk("hold_a_av_cnt", a_av_cnt, 1);
        chk("hold_b_av_cnt", b_av_cnt, 1);
        chk("hold_a_pix", a_pix, 32'h1234_5678);
        chk("hold_b_pix", b_pix, 32'h1234_5678);
        chk("hold_a_err_sticky", err_a, 1);
        run_req(BASE + 32'd20, 8, 7);
        chk_good("rereq", 12'd5, 32'h00AB_CDEF);
        chk("rereq_a_count", cnt_a, 7);
        chk("rereq_b_count", cnt_b, 7);

        // Reset in the WAIT state of both instances.
        addr_pixel    = BASE + 32'd20;
        request_pixel = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        res_n = 1'b0;
        #1;
        chk_zero("midrst");
        @(posedge clk);
        #1;
        res_n = 1'b1;
        observe(8, 7);
        chk_good("afterrst", 12'd5, 32'h00AB_CDEF);
        chk("afterrst_a_count", cnt_a, 1);
        chk("afterrst_b_count", cnt_b, 1);
        chk("afterrst_a_err", err_a, 0);

        // Counter saturation.
        force dut_a.cnt_q = 16'hFFFE;
        force dut_b.cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut_a.cnt_q;
        release dut_b.cnt_q;
        @(posedge clk);
        #1;
        chk("sat_pre_a", cnt_a, 16'hFFFE);
        run_req(BASE + 32'd20, 8, 7);
        chk("sat1_a", cnt_a, 16'hFFFF);
        chk("sat1_b", cnt_b, 16'hFFFF);
        run_req(BASE + 32'd20, 8, 7);
        chk("sat2_a", cnt_a, 16'hFFFF);
        chk("sat2_b", cnt_b, 16'hFFFF);
        chk("sat2_a_av_cnt", a_av_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
